ifpcu: RTL

- Instruction-fetch memory unit: accepts physical fetch addresses from the fetch stage and performs single-beat AXI4 read transactions toward instruction memory.
- Returns the 32-bit instruction word, or an error indication, on a valid/ready response channel.
- Sits between the fetch stage's request/response message ports and the instruction-side AXI master.
- Supports one outstanding transaction. Flush discards any in-flight or buffered result.

---
 rtl/ifpcu_pkg.sv | 27 ++
 rtl/ifpcu.sv | 116 +++++++++++
 2 files changed

// File: rtl/ifpcu_pkg.sv
// Shared encodings for the instruction-fetch memory unit: FSM states,
// response error codes, AXI constants and the response buffer layout.
package ifpcu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_BUS  = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } resp_t;

  function automatic logic [1:0] rresp_to_err(input logic [1:0] rresp);
    return (rresp != RESP_OKAY) ? ERR_BUS : ERR_NONE;
  endfunction

endpackage

// File: rtl/ifpcu.sv
// Instruction-fetch memory unit: turns fetch requests into single-beat AXI4
// reads and returns the word (or an error code) through a one-entry buffer.
module ifpcu
  import ifpcu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [1:0]        resp_err,
  input  logic              flush,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast
);

  logic [1:0]        r_state;
  logic              r_kill;
  logic [ADDR_W-1:0] r_addr;
  resp_t             r_resp;

  logic w_req_fire;
  logic w_aligned;
  logic w_ar_fire;
  logic w_r_beat;
  logic w_discard;
  logic w_resp_fire;
  logic w_bus_err;

  assign req_ready   = (r_state == ST_IDLE) && !flush;
  assign w_req_fire  = req_valid && req_ready;
  assign w_aligned   = (req_addr[1:0] == 2'b00);
  assign w_ar_fire   = m_arvalid && m_arready;
  assign w_r_beat    = m_rvalid && m_rready && m_rlast;
  // A flush arriving on the same cycle as the beat kills it just like a stored kill.
  assign w_discard   = r_kill || flush;
  assign w_resp_fire = resp_valid && resp_ready;
  assign w_bus_err   = (m_rresp != RESP_OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_kill  <= 1'b0;
      r_addr  <= '0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            if (w_aligned) begin
              r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_state <= ST_AR;
            end else begin
              r_resp.instr <= '0;
              r_resp.err   <= ERR_ADDR;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_AR: begin
          // AR is never withdrawn; a flush only marks the eventual beat for discard.
          if (flush) r_kill <= 1'b1;
          if (w_ar_fire) r_state <= ST_R;
        end
        ST_R: begin
          if (w_r_beat) begin
            if (w_discard) begin
              r_kill  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_resp.instr <= w_bus_err ? 32'd0 : m_rdata[31:0];
              r_resp.err   <= rresp_to_err(m_rresp);
              r_state      <= ST_RESP;
            end
          end else if (flush) begin
            r_kill <= 1'b1;
          end
        end
        ST_RESP: begin
          if (w_resp_fire || flush) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_arvalid  = (r_state == ST_AR);
  assign m_rready   = (r_state == ST_R);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_instr = r_resp.instr;
  assign resp_err   = r_resp.err;
  assign m_araddr   = r_addr;
  assign m_arid     = ID_W'(AXI_ID);
  assign m_arlen    = 8'd0;
  assign m_arsize   = SIZE_4B;
  assign m_arburst  = BURST_INCR;

endmodule
